keypad_number_entry: RTL
========================

// Module: keypad_number_entry
// PURPOSE
//  Input-side counterpart of the seven-segment display driver. Scans a 4x4 matrix keypad
//  (Pmod KYPD) and debounces presses. Assembles up to 4 decimal digits into a binary number.
//  entry_value drives the display's 16-bit number input live. number_out/number_valid hand a
//  committed value to the processor I/O.
// PARAMETERS
//  SCAN_CYCLES     100000  clocks per column slot (1 ms @ 100 MHz); >= 4
//  DEBOUNCE_SCANS  4       consecutive full scans a key state must be stable to be accepted; >= 1
// PORTS
//  clock_100Mhz   in   1   system clock
//  reset          in   1   asynchronous, active-high reset
//  row_n          in   4   keypad rows, active-low, pulled up; asynchronous to clock
//  col_n          out  4   keypad columns, active-low, exactly one low at any time
//  key_valid      out  1   one-cycle pulse per accepted press
//  key_code       out  4   hex code of the last accepted key (held between presses)
//  entry_value    out  16  binary value of digits currently being typed (0..9999)
//  digit_count    out  3   digits currently in the entry buffer (0..4)
//  number_out     out  16  last committed value (held until the next commit)
//  number_valid   out  1   one-cycle pulse when number_out is updated
// BEHAVIOUR
//  Reset: col_n=4'b1110; all other outputs and internal state 0; scan restarts at column 0.
//  Reset mid-press discards the press. No key_valid follows until the release/press is debounced.
//  Sync: row_n passes a 2-flop synchronizer before any use.
//  Scan: slot counter 0..SCAN_CYCLES-1. col_n cycles 1110->1101->1011->0111->1110, advancing on wrap.
//  Rows are sampled on the last cycle of each slot. A full scan is 4 slots.
//  Key map (col0..col3 x row0..row3):
//   col0 = 1,4,7,0; col1 = 2,5,8,F; col2 = 3,6,9,E; col3 = A,B,C,D.
//  Scan result per full scan: exactly one low row/col intersection gives that key.
//  Zero intersections gives NONE. Two or more gives INVALID, treated as NONE for acceptance.
//  Debounce FSM:
//   IDLE: on a key result, load the candidate and count 1 and go to PRESS_WAIT.
//   PRESS_WAIT: the same key adds 1 to the count; anything else returns to IDLE.
//    When count reaches DEBOUNCE_SCANS, go to HELD.
//    In the same clock, assert key_valid for 1 cycle and update key_code.
//    With DEBOUNCE_SCANS=1, go from IDLE straight to HELD and pulse key_valid.
//   HELD: a NONE result adds 1 to the count; any key result resets the count to 0.
//    When count reaches DEBOUNCE_SCANS, return to IDLE.
//    A key change while held never produces a second key_valid; the key must be released first.
//  Entry (registered, in the cycle after key_valid):
//   digits 0-9: if digit_count<4, shift the BCD buffer left one digit and insert the new digit.
//    digit_count+1. If digit_count=4, the digit is ignored and key_valid still pulses.
//   A (clear): buffer=0, digit_count=0.
//   B (backspace): if digit_count>0, shift the buffer right one digit and decrement digit_count.
//   F (enter): if digit_count>0, number_out=entry_value, pulse number_valid for 1 cycle.
//    Then clear the buffer and digit_count. If digit_count=0, do nothing.
//   C, D, E: no entry effect.
//  entry_value = d3*1000+d2*100+d1*10+d0, zero-extended to 16 bits.
//   Registered with the buffer; max 9999, no overflow possible.
//  Latency: a press held steadily from slot start produces key_valid at the end of scan DEBOUNCE_SCANS.
//   entry_value and number_out follow 1 cycle later.
// TESTING  (SCAN_CYCLES=4, DEBOUNCE_SCANS=2, each key held 3 scans, released 3 scans)
//  Assert reset mid-slot -> col_n=1110 asynchronously; all outputs 0; scanning resumes after release.
//  Press 1,2,3,4 -> one key_valid each; entry_value=1,12,123,1234; digit_count=4.
//  Press 5 -> key_valid pulses with key_code=5; entry_value stays 1234.
//  Press B -> entry_value 123, digit_count 3.
//   Press A -> entry_value 0, digit_count 0.
//   Press B again -> no change.
//  Type 0,4,2 then F -> number_out=42; number_valid high exactly 1 cycle; entry 0.
//   Press F again -> no pulse.
//  Press 7 for 1 scan only -> no key_valid.
//   Press 7+8 together for 3 scans -> no key_valid.
//   Hold 9 and add 6 -> only one key_valid (9).

Source files
------------

// File: rtl/keypad_number_entry_if.sv
// Keypad entry bus: matrix pins toward the keypad, key/number results toward the system.
interface keypad_number_entry_if;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry_value;
  logic [2:0]  digit_count;
  logic [15:0] number_out;
  logic        number_valid;

  modport master (
    input  row_n,
    output col_n, key_valid, key_code, entry_value, digit_count, number_out, number_valid
  );
  modport slave (
    output row_n,
    input  col_n, key_valid, key_code, entry_value, digit_count, number_out, number_valid
  );
endinterface

// File: rtl/keypad_number_entry.sv
// 4x4 keypad scanner with per-scan debounce and a 4-digit decimal entry buffer.
// Accepted digits build entry_value live; F commits it to number_out.
module keypad_number_entry #(
  parameter int SCAN_CYCLES    = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                   clock_100Mhz,
  input  logic                   reset,
  keypad_number_entry_if.master  kp
);
  localparam int SW = $clog2(SCAN_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_SCANS);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_WAIT = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;

  function automatic logic [3:0] key_map(input logic [1:0] col, input logic [1:0] row);
    case ({col, row})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h4;  4'h2: key_map = 4'h7;  4'h3: key_map = 4'h0;
      4'h4: key_map = 4'h2;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h8;  4'h7: key_map = 4'hF;
      4'h8: key_map = 4'h3;  4'h9: key_map = 4'h6;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hE;
      4'hC: key_map = 4'hA;  4'hD: key_map = 4'hB;  4'hE: key_map = 4'hC;  default: key_map = 4'hD;
    endcase
  endfunction

  function automatic logic [15:0] bcd_to_bin(input logic [3:0][3:0] d);
    bcd_to_bin = 16'(d[3]) * 16'd1000 + 16'(d[2]) * 16'd100 + 16'(d[1]) * 16'd10 + 16'(d[0]);
  endfunction

  // ---------------- row sync and column scan ----------------
  logic [3:0]    row_s1, row_s2;
  logic [SW-1:0] slot_cnt;
  logic [1:0]    col_idx;
  logic [1:0]    acc_hits;
  logic [3:0]    acc_key;

  logic          slot_end, scan_done;
  logic [2:0]    col_hits, hit_sum;
  logic [1:0]    row_sel;
  logic [3:0]    col_key, scan_key;
  logic          res_key, res_none;

  assign slot_end  = (slot_cnt == SW'(SCAN_CYCLES - 1));
  assign scan_done = slot_end && (col_idx == 2'd3);
  assign kp.col_n  = ~(4'b0001 << col_idx);

  always_comb begin
    col_hits = '0;
    row_sel  = '0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2[r]) begin
        col_hits = col_hits + 3'd1;
        row_sel  = 2'(r);
      end
    end
    col_key  = key_map(col_idx, row_sel);
    hit_sum  = {1'b0, acc_hits} + col_hits;
    scan_key = (col_hits == 3'd1) ? col_key : acc_key;
    res_key  = scan_done && (hit_sum == 3'd1);
    res_none = scan_done && (hit_sum == 3'd0);
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      row_s1   <= '0;
      row_s2   <= '0;
      slot_cnt <= '0;
      col_idx  <= '0;
      acc_hits <= '0;
      acc_key  <= '0;
    end else begin
      row_s1 <= kp.row_n;
      row_s2 <= row_s1;
      if (slot_end) begin
        slot_cnt <= '0;
        col_idx  <= col_idx + 2'd1;
        if (col_idx == 2'd3) begin
          acc_hits <= '0;
          acc_key  <= '0;
        end else begin
          // saturate at 2: anything beyond one intersection is already INVALID
          acc_hits <= (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
          if (col_hits == 3'd1) acc_key <= col_key;
        end
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end
    end
  end

  // ---------------- debounce ----------------
  logic [1:0]    state;
  logic [CW-1:0] db_cnt;
  logic [3:0]    cand;
  logic          key_valid;
  logic [3:0]    key_code;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      db_cnt    <= '0;
      cand      <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      key_valid <= 1'b0;
      if (scan_done) begin
        case (state)
          IDLE: if (res_key) begin
            cand <= scan_key;
            if (DEBOUNCE_SCANS == 1) begin
              state     <= HELD;
              db_cnt    <= '0;
              key_valid <= 1'b1;
              key_code  <= scan_key;
            end else begin
              state  <= PRESS_WAIT;
              db_cnt <= CW'(1);
            end
          end
          PRESS_WAIT: begin
            if (res_key && scan_key == cand) begin
              if (db_cnt + CW'(1) == DB_MAX) begin
                state     <= HELD;
                db_cnt    <= '0;
                key_valid <= 1'b1;
                key_code  <= cand;
              end else begin
                db_cnt <= db_cnt + CW'(1);
              end
            end else begin
              state  <= IDLE;
              db_cnt <= '0;
            end
          end
          HELD: begin
            // only a clean all-up scan counts as release; a multi-key scan keeps the hold
            if (res_none) begin
              if (db_cnt + CW'(1) == DB_MAX) begin
                state  <= IDLE;
                db_cnt <= '0;
              end else begin
                db_cnt <= db_cnt + CW'(1);
              end
            end else begin
              db_cnt <= '0;
            end
          end
          default: begin
            state  <= IDLE;
            db_cnt <= '0;
          end
        endcase
      end
    end
  end

  // ---------------- entry buffer ----------------
  logic [3:0][3:0] bcd, bcd_nx;
  logic [2:0]      dcount, dcount_nx;
  logic            commit;
  logic [15:0]     entry_value, number_out;
  logic            number_valid;

  always_comb begin
    bcd_nx    = bcd;
    dcount_nx = dcount;
    commit    = 1'b0;
    if (key_valid) begin
      if (key_code <= 4'd9) begin
        if (dcount < 3'd4) begin
          bcd_nx    = {bcd[2:0], key_code};
          dcount_nx = dcount + 3'd1;
        end
      end else begin
        case (key_code)
          4'hA: begin
            bcd_nx    = '0;
            dcount_nx = '0;
          end
          4'hB: if (dcount != 3'd0) begin
            bcd_nx    = {4'h0, bcd[3:1]};
            dcount_nx = dcount - 3'd1;
          end
          4'hF: if (dcount != 3'd0) begin
            commit    = 1'b1;
            bcd_nx    = '0;
            dcount_nx = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      bcd          <= '0;
      dcount       <= '0;
      entry_value  <= '0;
      number_out   <= '0;
      number_valid <= 1'b0;
    end else begin
      bcd          <= bcd_nx;
      dcount       <= dcount_nx;
      entry_value  <= bcd_to_bin(bcd_nx);
      number_valid <= commit;
      if (commit) number_out <= entry_value;
    end
  end

  assign kp.key_valid    = key_valid;
  assign kp.key_code     = key_code;
  assign kp.entry_value  = entry_value;
  assign kp.digit_count  = dcount;
  assign kp.number_out   = number_out;
  assign kp.number_valid = number_valid;
endmodule
